// File: rtl/xor_stream_cipher.sv
// Serial XOR cipher core: one shared data pin loads key and message, the core XORs them
// (repeated or rolling key) and shifts the ciphertext out MSB first with a valid flag.
module xor_stream_cipher #(
    parameter int MSG_SIZE = 64,
    parameter int KEY_SIZE = 8
) (
    input  logic clk,
    input  logic rst_n,
    input  logic ena,
    input  logic iData_in,
    input  logic iKey_flag,
    input  logic iMsg_flag,
    input  logic iMode,
    output logic oKey_valid,
    output logic oBusy,
    output logic oEnc_status,
    output logic oData_flag,
    output logic oData_out
);

    localparam int KCW    = $clog2(KEY_SIZE) + 1;
    localparam int MCW    = $clog2(MSG_SIZE) + 1;
    localparam int NCHUNK = MSG_SIZE / KEY_SIZE;

    localparam logic [KCW-1:0] KEY_FULL = KCW'(KEY_SIZE);
    localparam logic [MCW-1:0] MSG_FULL = MCW'(MSG_SIZE);
    localparam logic [MCW-1:0] OUT_LAST = MCW'(MSG_SIZE - 1);

    typedef enum logic [1:0] {
        IDLE,
        ENCRYPT,
        SHIFT
    } state_t;

    state_t                state_q,   state_d;
    logic [KEY_SIZE-1:0]   key_q,     key_d;
    logic [MSG_SIZE-1:0]   msg_q,     msg_d;
    logic [MSG_SIZE-1:0]   ct_q,      ct_d;
    logic [KCW-1:0]        key_cnt_q, key_cnt_d;
    logic [MCW-1:0]        msg_cnt_q, msg_cnt_d;
    logic [MCW-1:0]        out_cnt_q, out_cnt_d;
    logic                  key_flag_q;
    logic                  msg_flag_q;

    logic                  key_rise;
    logic                  msg_rise;
    logic [KCW-1:0]        key_cnt_base;
    logic [MCW-1:0]        msg_cnt_base;

    function automatic logic [KEY_SIZE-1:0] rotl(input logic [KEY_SIZE-1:0] k, input int amt);
        logic [2*KEY_SIZE-1:0] dbl;
        dbl = {k, k} << amt;
        return dbl[2*KEY_SIZE-1 -: KEY_SIZE];
    endfunction

    // Chunk 0 is the MSB chunk; rolling mode rotates the key left by the chunk index.
    function automatic logic [MSG_SIZE-1:0] encrypt(input logic [MSG_SIZE-1:0] msg,
                                                    input logic [KEY_SIZE-1:0] key,
                                                    input logic                rolling);
        logic [MSG_SIZE-1:0] res;
        logic [KEY_SIZE-1:0] kj;
        res = '0;
        for (int j = 0; j < NCHUNK; j++) begin
            kj = rolling ? rotl(key, j % KEY_SIZE) : key;
            res[MSG_SIZE-1-j*KEY_SIZE -: KEY_SIZE] = msg[MSG_SIZE-1-j*KEY_SIZE -: KEY_SIZE] ^ kj;
        end
        return res;
    endfunction

    assign key_rise     = iKey_flag & ~key_flag_q;
    assign msg_rise     = iMsg_flag & ~msg_flag_q;
    assign key_cnt_base = key_rise ? '0 : key_cnt_q;
    assign msg_cnt_base = msg_rise ? '0 : msg_cnt_q;

    always_comb begin
        // NOTE: every variable gets its hold value first so no path leaves it unassigned (no latch).
        state_d   = state_q;
        key_d     = key_q;
        msg_d     = msg_q;
        ct_d      = ct_q;
        key_cnt_d = key_cnt_q;
        msg_cnt_d = msg_cnt_q;
        out_cnt_d = out_cnt_q;

        case (state_q)
            IDLE: begin
                // Key has priority; with both flags high the message bit is dropped entirely.
                if (iKey_flag) begin
                    key_cnt_d = key_cnt_base;
                    if (key_cnt_base != KEY_FULL) begin
                        key_d     = {key_q[KEY_SIZE-2:0], iData_in};
                        key_cnt_d = key_cnt_base + KCW'(1);
                    end
                end else if (iMsg_flag) begin
                    msg_cnt_d = msg_cnt_base;
                    if (msg_cnt_base != MSG_FULL) begin
                        msg_d     = {msg_q[MSG_SIZE-2:0], iData_in};
                        msg_cnt_d = msg_cnt_base + MCW'(1);
                    end
                end
                if (key_cnt_d == KEY_FULL && msg_cnt_d == MSG_FULL) begin
                    state_d = ENCRYPT;
                end
            end
            ENCRYPT: begin
                ct_d      = encrypt(msg_q, key_q, iMode);
                out_cnt_d = '0;
                state_d   = SHIFT;
            end
            SHIFT: begin
                ct_d = {ct_q[MSG_SIZE-2:0], 1'b0};
                if (out_cnt_q == OUT_LAST) begin
                    out_cnt_d = '0;
                    msg_cnt_d = '0;
                    state_d   = IDLE;
                end else begin
                    out_cnt_d = out_cnt_q + MCW'(1);
                end
            end
            default: state_d = IDLE;
        endcase
    end

    // NOTE: sequential state uses non-blocking assignments so all registers update together.
    always_ff @(posedge clk or negedge rst_n) begin
        if (!rst_n) begin
            state_q    <= IDLE;
            key_q      <= '0;
            msg_q      <= '0;
            ct_q       <= '0;
            key_cnt_q  <= '0;
            msg_cnt_q  <= '0;
            out_cnt_q  <= '0;
            key_flag_q <= 1'b0;
            msg_flag_q <= 1'b0;
        end else if (ena) begin
            state_q    <= state_d;
            key_q      <= key_d;
            msg_q      <= msg_d;
            ct_q       <= ct_d;
            key_cnt_q  <= key_cnt_d;
            msg_cnt_q  <= msg_cnt_d;
            out_cnt_q  <= out_cnt_d;
            key_flag_q <= iKey_flag;
            msg_flag_q <= iMsg_flag;
        end
    end

    // Outputs decode directly from registers, so an asynchronous reset clears them at once.
    assign oKey_valid  = (key_cnt_q == KEY_FULL);
    assign oBusy       = (state_q != IDLE);
    assign oEnc_status = (state_q == ENCRYPT);
    assign oData_flag  = (state_q == SHIFT);
    assign oData_out   = oData_flag & ct_q[MSG_SIZE-1];

endmodule
